// File: rtl/user_move_pkg.sv
// Shared state encodings, empty-square code and piece field helpers for the player-move controller.
// Pure declarations: no latency, no backpressure.
package user_move_pkg;

    typedef enum logic [2:0] {
        ST_START  = 3'd0,
        ST_SELECT = 3'd1,
        ST_TARGET = 3'd2,
        ST_CHECK  = 3'd3,
        ST_PLACE  = 3'd4,
        ST_CLEAR  = 3'd5
    } state_t;

    localparam int MAX_PW = 16;
    localparam logic [MAX_PW-1:0] EMPTY = '0;

    // Pieces are passed zero-extended to MAX_PW; pw is the real field width.
    function automatic logic piece_colour(input logic [MAX_PW-1:0] p, input int pw);
        return p[pw-1];
    endfunction

    function automatic logic [MAX_PW-1:0] piece_type(input logic [MAX_PW-1:0] p, input int pw);
        logic [MAX_PW-1:0] mask;
        mask = (MAX_PW'(1) << (pw - 1)) - MAX_PW'(1);
        return p & mask;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge press detector for a vector of button levels, with optional held-button auto-repeat.
// Press is combinational from the current level (same cycle); no backpressure.
module btn_edge #(
    parameter int W = 1
`ifdef USER_MOVE_REPEAT_EN
    ,
    parameter bit RPT_EN = 1'b0,
    parameter int DELAY  = 25_000_000,
    parameter int PERIOD = 5_000_000
`endif
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] lvl,
    output logic [W-1:0] press
);

    logic [W-1:0] prev;

    always_ff @(posedge clk) begin
        if (reset) prev <= '0;
        else       prev <= lvl;
    end

`ifdef USER_MOVE_REPEAT_EN
    localparam int CNT_W = $clog2(DELAY > PERIOD ? DELAY : PERIOD) + 1;

    logic [CNT_W-1:0] cnt;
    logic             first;
    logic             rep;

    // One shared counter: any change in the held set restarts the delay phase.
    assign rep = RPT_EN && (lvl != '0) && (lvl == prev) &&
                 (cnt == (first ? CNT_W'(DELAY - 1) : CNT_W'(PERIOD - 1)));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            first <= 1'b1;
        end else if ((lvl != prev) || (lvl == '0)) begin
            cnt   <= '0;
            first <= 1'b1;
        end else if (rep) begin
            cnt   <= '0;
            first <= 1'b0;
        end else begin
            cnt   <= cnt + CNT_W'(1);
        end
    end

    assign press = (lvl & ~prev) | (rep ? lvl : '0);
`else
    assign press = lvl & ~prev;
`endif

endmodule

// File: rtl/user_move_fsm.sv
// Player input controller: cursor, piece selection, checked move and two-write commit (USER_MOVE_REPEAT_EN adds auto-repeat).
// All outputs registered, one cycle after the press; checker handshake holds chk_req until chk_ack.
module user_move_fsm
    import user_move_pkg::*;
#(
    parameter int BOARD_DIM     = 8,
    parameter int PIECE_W       = 4,
    parameter int CW            = $clog2(BOARD_DIM),
    parameter int AW            = 2 * CW,
    parameter int SQ            = BOARD_DIM * BOARD_DIM,
    parameter logic [AW-1:0] CURSOR_INIT = AW'(6'b100110),
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [SQ*PIECE_W-1:0] entireBoard,
    input  logic                  BTNC,
    input  logic                  BTNU,
    input  logic                  BTND,
    input  logic                  BTNL,
    input  logic                  BTNR,
    output logic                  chk_req,
    output logic [AW-1:0]         chk_from,
    output logic [AW-1:0]         chk_to,
    input  logic                  chk_ack,
    input  logic                  chk_ok,
    output logic                  wr_en,
    output logic [AW-1:0]         wr_addr,
    output logic [PIECE_W-1:0]    wr_data,
    output logic [AW-1:0]         cursorLocation,
    output logic [AW-1:0]         selectionLocation,
    output logic                  selectionCheck,
    output logic                  playerTurn,
    output logic [2:0]            currentState,
    output logic                  move_done
);

    localparam logic [CW-1:0] EDGE_MAX = CW'(BOARD_DIM - 1);

    logic               c_press;
    logic [3:0]         dir_press;   // {L, R, D, U}
    logic [PIECE_W-1:0] board [SQ];

    btn_edge #(.W(1)) u_btn_c (
        .clk   (clk),
        .reset (reset),
        .lvl   (BTNC),
        .press (c_press)
    );

    btn_edge #(
        .W(4)
`ifdef USER_MOVE_REPEAT_EN
        , .RPT_EN(1'b1), .DELAY(REPEAT_DELAY), .PERIOD(REPEAT_PERIOD)
`endif
    ) u_btn_dir (
        .clk   (clk),
        .reset (reset),
        .lvl   ({BTNL, BTNR, BTND, BTNU}),
        .press (dir_press)
    );

    for (genvar n = 0; n < SQ; n++) begin : g_board
        assign board[n] = entireBoard[n*PIECE_W +: PIECE_W];
    end

    state_t             state, state_nxt;
    logic [AW-1:0]      cursor_nxt, sel_nxt, from_nxt, to_nxt, wr_addr_nxt;
    logic [PIECE_W-1:0] wr_data_nxt;
    logic               selchk_nxt, req_nxt, wr_en_nxt, done_nxt, turn_nxt;
    logic [MAX_PW-1:0]  cur_piece;
    logic [CW-1:0]      file, rank;
    logic               sel_ok;

    always_comb begin
        cur_piece = '0;
        cur_piece[PIECE_W-1:0] = board[cursorLocation];
        file   = cursorLocation[AW-1:CW];
        rank   = cursorLocation[CW-1:0];
        sel_ok = (piece_type(cur_piece, PIECE_W) != EMPTY) &&
                 (piece_colour(cur_piece, PIECE_W) == playerTurn);

        state_nxt   = state;
        cursor_nxt  = cursorLocation;
        sel_nxt     = selectionLocation;
        selchk_nxt  = selectionCheck;
        req_nxt     = chk_req;
        from_nxt    = chk_from;
        to_nxt      = chk_to;
        wr_en_nxt   = 1'b0;
        wr_addr_nxt = wr_addr;
        wr_data_nxt = wr_data;
        done_nxt    = 1'b0;
        turn_nxt    = playerTurn;

        case (state)
            ST_START: state_nxt = ST_SELECT;
            ST_SELECT: begin
                if (c_press && sel_ok) begin
                    state_nxt  = ST_TARGET;
                    sel_nxt    = cursorLocation;
                    selchk_nxt = 1'b1;
                end
            end
            ST_TARGET: begin
                if (c_press) begin
                    if (cursorLocation == selectionLocation) begin
                        state_nxt  = ST_SELECT;
                        selchk_nxt = 1'b0;
                    end else begin
                        state_nxt = ST_CHECK;
                        from_nxt  = selectionLocation;
                        to_nxt    = cursorLocation;
                        req_nxt   = 1'b1;
                    end
                end
            end
            ST_CHECK: begin
                if (chk_req && chk_ack) begin
                    req_nxt = 1'b0;
                    if (chk_ok) begin
                        state_nxt   = ST_PLACE;
                        wr_en_nxt   = 1'b1;
                        wr_addr_nxt = chk_to;
                        wr_data_nxt = board[chk_from];
                    end else begin
                        state_nxt  = ST_SELECT;
                        selchk_nxt = 1'b0;
                    end
                end
            end
            ST_PLACE: begin
                state_nxt   = ST_CLEAR;
                wr_en_nxt   = 1'b1;
                wr_addr_nxt = chk_from;
                wr_data_nxt = '0;
                done_nxt    = 1'b1;
                turn_nxt    = ~playerTurn;
                selchk_nxt  = 1'b0;
            end
            ST_CLEAR: state_nxt = ST_SELECT;
            default:  state_nxt = ST_START;
        endcase

        // The winning direction is chosen before the edge test, so a blocked L masks R.
        if ((state == ST_SELECT) || (state == ST_TARGET)) begin
            if (dir_press[3]) begin
                if (file != '0) cursor_nxt = {file - CW'(1), rank};
            end else if (dir_press[2]) begin
                if (file != EDGE_MAX) cursor_nxt = {file + CW'(1), rank};
            end else if (dir_press[1]) begin
                if (rank != EDGE_MAX) cursor_nxt = {file, rank + CW'(1)};
            end else if (dir_press[0]) begin
                if (rank != '0) cursor_nxt = {file, rank - CW'(1)};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= ST_START;
            cursorLocation    <= CURSOR_INIT;
            selectionLocation <= '0;
            selectionCheck    <= 1'b0;
            chk_req           <= 1'b0;
            chk_from          <= '0;
            chk_to            <= '0;
            wr_en             <= 1'b0;
            wr_addr           <= '0;
            wr_data           <= '0;
            move_done         <= 1'b0;
            playerTurn        <= 1'b0;
        end else begin
            state             <= state_nxt;
            cursorLocation    <= cursor_nxt;
            selectionLocation <= sel_nxt;
            selectionCheck    <= selchk_nxt;
            chk_req           <= req_nxt;
            chk_from          <= from_nxt;
            chk_to            <= to_nxt;
            wr_en             <= wr_en_nxt;
            wr_addr           <= wr_addr_nxt;
            wr_data           <= wr_data_nxt;
            move_done         <= done_nxt;
            playerTurn        <= turn_nxt;
        end
    end

    assign currentState = state;

endmodule

// File: tb/tb_user_move_fsm.sv
// Directed bench for user_move_fsm: reset, clamping, selection, cancel, legal/rejected moves, reset mid-check.
// Inputs driven and outputs sampled 1ns after each rising edge.
module tb_user_move_fsm;

    localparam int AW = 6;
    localparam int PW = 4;
    localparam int SQ = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic [SQ*PW-1:0] entire_board;
    logic            btn_c, btn_u, btn_d, btn_l, btn_r;
    logic            chk_req, chk_ack, chk_ok;
    logic [AW-1:0]   chk_from, chk_to, wr_addr, cursor, sel_loc;
    logic            wr_en, sel_chk, turn, move_done;
    logic [PW-1:0]   wr_data;
    logic [2:0]      cur_state;

    int n_checks = 0;
    int n_pass   = 0;

    user_move_fsm #(
        .BOARD_DIM(8), .PIECE_W(PW), .CURSOR_INIT(6'b100110),
        .REPEAT_DELAY(25_000_000), .REPEAT_PERIOD(5_000_000)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .entireBoard       (entire_board),
        .BTNC              (btn_c),
        .BTNU              (btn_u),
        .BTND              (btn_d),
        .BTNL              (btn_l),
        .BTNR              (btn_r),
        .chk_req           (chk_req),
        .chk_from          (chk_from),
        .chk_to            (chk_to),
        .chk_ack           (chk_ack),
        .chk_ok            (chk_ok),
        .wr_en             (wr_en),
        .wr_addr           (wr_addr),
        .wr_data           (wr_data),
        .cursorLocation    (cursor),
        .selectionLocation (sel_loc),
        .selectionCheck    (sel_chk),
        .playerTurn        (turn),
        .currentState      (cur_state),
        .move_done         (move_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // mask = {C, U, D, L, R}; one-cycle press followed by one-cycle release
    task automatic press(input logic [4:0] mask);
        {btn_c, btn_u, btn_d, btn_l, btn_r} = mask;
        tick();
        {btn_c, btn_u, btn_d, btn_l, btn_r} = '0;
        tick();
    endtask

    task automatic set_sq(input int sq, input logic [PW-1:0] v);
        entire_board[sq*PW +: PW] = v;
    endtask

    localparam logic [4:0] P_C = 5'b10000, P_U = 5'b01000, P_D = 5'b00100,
                           P_L = 5'b00010, P_R = 5'b00001;

    initial begin
        reset = 1'b1;
        entire_board = '0;
        {btn_c, btn_u, btn_d, btn_l, btn_r} = '0;
        chk_ack = 1'b0;
        chk_ok  = 1'b0;
        tick(2);
        check("rst_state",  cur_state, 0);
        check("rst_cursor", cursor, 6'h26);
        check("rst_turn",   turn, 0);
        check("rst_req",    chk_req, 0);
        check("rst_wr_en",  wr_en, 0);
        check("rst_selchk", sel_chk, 0);
        check("rst_done",   move_done, 0);
        check("rst_wraddr", wr_addr, 0);
        reset = 1'b0;
        tick();
        check("start_to_select", cur_state, 1);

        // Walk to the corner, then probe the clamps
        repeat (4) press(P_L);
        repeat (6) press(P_U);
        check("corner", cursor, 6'h00);
        press(P_L);
        check("clamp_l", cursor, 6'h00);
        press(P_U);
        check("clamp_u", cursor, 6'h00);
        press(P_R);
        check("step_r", cursor, 6'h08);
        press(P_D);
        check("step_d", cursor, 6'h09);
        repeat (3) press(P_R);
        repeat (5) press(P_D);
        check("back_home", cursor, 6'h26);

        // Wrong colour is ignored, own piece selects
        set_sq(6'h26, 4'b1001);
        press(P_C);
        check("sel_black_ignored", cur_state, 1);
        check("sel_black_selchk", sel_chk, 0);
        set_sq(6'h26, 4'b0001);
        press(P_C);
        check("sel_state",  cur_state, 2);
        check("sel_loc",    sel_loc, 6'h26);
        check("sel_chk",    sel_chk, 1);

        // Cancel by pressing C on the selected square
        press(P_C);
        check("cancel_state",  cur_state, 1);
        check("cancel_selchk", sel_chk, 0);
        check("cancel_no_req", chk_req, 0);

        // Legal move 0x26 -> 0x25
        press(P_C);
        press(P_U);
        check("tgt_cursor", cursor, 6'h25);
        check("tgt_state", cur_state, 2);
        btn_c = 1'b1;
        tick();
        check("req_state", cur_state, 3);
        check("req_high",  chk_req, 1);
        check("req_from",  chk_from, 6'h26);
        check("req_to",    chk_to, 6'h25);
        btn_c = 1'b0;
        tick();
        check("req_hold1", chk_req, 1);
        tick();
        check("req_hold2", chk_req, 1);
        check("req_no_wr", wr_en, 0);
        chk_ack = 1'b1;
        chk_ok  = 1'b1;
        tick();
        chk_ack = 1'b0;
        chk_ok  = 1'b0;
        check("place_state", cur_state, 4);
        check("place_req",   chk_req, 0);
        check("place_wr_en", wr_en, 1);
        check("place_addr",  wr_addr, 6'h25);
        check("place_data",  wr_data, 4'b0001);
        check("place_done",  move_done, 0);
        check("place_turn",  turn, 0);
        tick();
        check("clear_state", cur_state, 5);
        check("clear_wr_en", wr_en, 1);
        check("clear_addr",  wr_addr, 6'h26);
        check("clear_data",  wr_data, 0);
        check("clear_done",  move_done, 1);
        check("clear_turn",  turn, 1);
        check("clear_selchk", sel_chk, 0);
        tick();
        check("post_state", cur_state, 1);
        check("post_wr_en", wr_en, 0);
        check("post_done",  move_done, 0);

        // Black's turn: reject path
        set_sq(6'h25, 4'b1010);
        set_sq(6'h26, 4'b0000);
        press(P_C);
        check("blk_sel_state", cur_state, 2);
        press(P_D);
        press(P_C);
        check("rej_req", chk_req, 1);
        check("rej_from", chk_from, 6'h25);
        check("rej_to", chk_to, 6'h26);
        chk_ack = 1'b1;
        chk_ok  = 1'b0;
        tick();
        chk_ack = 1'b0;
        check("rej_state",  cur_state, 1);
        check("rej_req_lo", chk_req, 0);
        check("rej_wr_en",  wr_en, 0);
        check("rej_turn",   turn, 1);
        check("rej_selchk", sel_chk, 0);
        tick();
        check("rej_wr_en2", wr_en, 0);

        // Stray ack outside CHECK does nothing
        chk_ack = 1'b1;
        chk_ok  = 1'b1;
        tick();
        chk_ack = 1'b0;
        chk_ok  = 1'b0;
        check("stray_ack_state", cur_state, 1);
        check("stray_ack_wr_en", wr_en, 0);

        // Repeat the request, then reset while it is pending
        press(P_U);
        press(P_C);
        press(P_D);
        press(P_C);
        check("rpt_req", chk_req, 1);
        check("rpt_state", cur_state, 3);
        reset = 1'b1;
        tick();
        check("mid_rst_req",    chk_req, 0);
        check("mid_rst_state",  cur_state, 0);
        check("mid_rst_cursor", cursor, 6'h26);
        check("mid_rst_turn",   turn, 0);
        check("mid_rst_selchk", sel_chk, 0);
        check("mid_rst_from",   chk_from, 0);
        reset = 1'b0;
        tick();
        check("mid_rst_resume", cur_state, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/user_move_fsm.md
# user_move_fsm

Parametrised player-input controller for the chess datapath. It turns raw push-button levels into a cursor position, a piece selection and a checked move. Each move is validated through a request/acknowledge handshake with an external move checker, and is then committed to the board store as a two-write sequence (place, then clear). It sits between the button synchroniser and the board builder/VGA overlay, and supports square boards of any power-of-two size with optional held-button auto-repeat.

## Interface
- BOARD_DIM, 8: squares per side; power of two, ≥2. CW = $clog2(BOARD_DIM), AW = 2*CW, SQ = BOARD_DIM².
- PIECE_W, 4: bits per square; bit PIECE_W-1 = colour (0 white, 1 black); bits PIECE_W-2:0 = type; type 0 = empty.
- CURSOR_INIT, 6'b100110: cursor after reset; address = {file[CW-1:0], rank[CW-1:0]}.
- REPEAT_DELAY, 25_000_000: cycles held before first auto-repeat.
- REPEAT_PERIOD, 5_000_000: cycles between subsequent repeats.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- entireBoard  in  SQ*PIECE_W  square n at bits [n*PIECE_W +: PIECE_W].
- BTNC, BTNU, BTND, BTNL, BTNR  in  1 each  synchronised button levels.
- chk_req  out  1  move-check request, held until acknowledged.
- chk_from, chk_to  out  AW each  squares under check.
- chk_ack  in  1  checker response strobe.
- chk_ok  in  1  move legal; sampled only when chk_ack=1.
- wr_en  out  1  board write strobe.
- wr_addr  out  AW  write square.
- wr_data  out  PIECE_W  write content.
- cursorLocation  out  AW  current cursor.
- selectionLocation  out  AW  selected square.
- selectionCheck  out  1  selection active.
- playerTurn  out  1  0 white, 1 black.
- currentState  out  3  FSM state encoding.
- move_done  out  1  one-cycle pulse per committed move.

## Operation
- Buttons are rising-edge detected; all prior-level registers reset to 0. A button held through reset therefore yields one press on the first cycle after reset.
- States: START(0), SELECT(1), TARGET(2), CHECK(3), PLACE(4), CLEAR(5).
- START: unconditional transition to SELECT on the next cycle.
- SELECT: a C press with type(board[cursor])≠0 and colour==playerTurn → TARGET; selectionLocation←cursor, selectionCheck←1. Any other C press is ignored.
- TARGET, C press with cursor==selectionLocation → SELECT, selectionCheck←0 (cancel; no request issued).
- TARGET, C press otherwise → CHECK; chk_from←selectionLocation, chk_to←cursor, chk_req←1.
- CHECK: chk_req held high until chk_ack.
  - chk_ack & chk_ok → PLACE.
  - chk_ack & !chk_ok → SELECT, selectionCheck←0, turn unchanged.
- PLACE: wr_en=1, wr_addr=chk_to, wr_data=board[chk_from] (sampled on entry). Then → CLEAR.
- CLEAR: wr_en=1, wr_addr=chk_from, wr_data=0. move_done=1, playerTurn toggles, selectionCheck←0. Then → SELECT.
- Cursor: moves only in SELECT and TARGET; frozen in START, CHECK, PLACE and CLEAR.
  - Direction priority L>R>D>U; one step per press.
  - L: file−1. R: file+1. D: rank+1. U: rank−1.
  - Clamp at the edges (no wrap); a press against an edge is dropped.
- Simultaneous C and direction press: C is evaluated against the pre-move cursor; the cursor also moves that cycle.

## Timing
- All outputs are registered.
- Reset values:
  - state START, cursorLocation=CURSOR_INIT, playerTurn=0.
  - selectionLocation=0, selectionCheck=0.
  - chk_req=0, chk_from=0, chk_to=0.
  - wr_en=0, wr_addr=0, wr_data=0, move_done=0.
- Press at cycle n (button high at n, low at n−1) → state/cursor update visible at n+1.
- chk_req rises 1 cycle after the C press and falls in the cycle after chk_ack is sampled. chk_ack arriving on the same cycle chk_req rises is accepted.
- chk_ack while chk_req=0 is ignored.
- Commit sequence after accepted ack: wr_en high for exactly two consecutive cycles (PLACE, then CLEAR). move_done and the playerTurn change appear in the CLEAR cycle.
- Reset mid-operation has priority: every output returns to its reset value on the next edge, including chk_req and wr_en.

## Configuration
- USER_MOVE_REPEAT_EN defined:
  - A held direction button generates its edge press, then a repeat after REPEAT_DELAY cycles, then one every REPEAT_PERIOD cycles.
  - A single shared counter restarts whenever the set of held direction buttons changes.
  - BTNC never repeats.
- USER_MOVE_REPEAT_EN undefined: one step per rising edge; REPEAT_* parameters are ignored and no counter is synthesised.

## Structure
- Package user_move_pkg:
  - state localparams (START…CLEAR);
  - EMPTY type code;
  - piece-colour/piece-type extraction functions parameterised on PIECE_W.
- Sub-module btn_edge: per-button edge detector with optional repeat counter. Instantiated once for C (repeat tied off) and once as a 4-bit vector for U/D/L/R.

## Test plan
- Reset, then idle: cursorLocation=0x26, playerTurn=0, all other outputs 0; currentState 0 → 1 on the next cycle.
- Clamp: cursor driven to 0x00, press L then U → 0x00; press R → 0x08; press D → 0x09.
- Select: board[0x26]=4'b1001 with playerTurn=0, C → stays SELECT. Set board[0x26]=4'b0001, C → TARGET, selectionLocation=0x26, selectionCheck=1.
- Cancel: in TARGET with cursor=0x26, C → SELECT, selectionCheck=0; chk_req never asserted.
- Legal move: U to 0x25, C → chk_req=1, chk_from=0x26, chk_to=0x25. chk_ack=chk_ok=1 after 3 cycles → write 0x25←4'b0001, next cycle 0x26←0, move_done=1, playerTurn=1.
- Reject and reset: chk_ack=1 with chk_ok=0 → SELECT, no wr_en, playerTurn unchanged. Repeat the request, assert reset while chk_req=1 → chk_req=0 and state START on the next edge.
